// File: rtl/img_pkg.sv
// ============================================================================
// Module   : img_pkg
// Brief    : Shared types and constants for the BMP image writer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package img_pkg;

  typedef enum logic [1:0] {
    S_HEADER = 2'd0,
    S_ACCEPT = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } img_state_t;

  localparam int BMP_HDR_BYTES  = 54;
  localparam int IMG_WIDTH_DEF  = 768;
  localparam int IMG_HEIGHT_DEF = 512;

  localparam logic [5:0] OFF_SIGNATURE   = 6'd0;
  localparam logic [5:0] OFF_FILE_SIZE   = 6'd2;
  localparam logic [5:0] OFF_RESERVED    = 6'd6;
  localparam logic [5:0] OFF_DATA_OFFSET = 6'd10;
  localparam logic [5:0] OFF_DIB_SIZE    = 6'd14;
  localparam logic [5:0] OFF_WIDTH       = 6'd18;
  localparam logic [5:0] OFF_HEIGHT      = 6'd22;
  localparam logic [5:0] OFF_PLANES      = 6'd26;
  localparam logic [5:0] OFF_BPP         = 6'd28;
  localparam logic [5:0] OFF_COMPRESSION = 6'd30;
  localparam logic [5:0] OFF_IMAGE_SIZE  = 6'd34;

  // Byte of a little-endian field of len bytes at off; zero outside the field.
  function automatic logic [7:0] le_field(input logic [31:0] val, input logic [5:0] idx,
                                          input logic [5:0] off, input logic [2:0] len);
    logic [5:0] rel;
    rel      = idx - off;
    le_field = 8'h00;
    if ((idx >= off) && (rel < {3'b000, len})) begin
      le_field = val[{rel[1:0], 3'b000} +: 8];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/img_write_bmp_header_rom.sv
// ============================================================================
// Module   : bmp_header_rom
// Brief    : Combinational 54-byte BMP/DIB header, indexed by byte position.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bmp_header_rom
  import img_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH_DEF,
  parameter int HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic [5:0] index,
  output logic [7:0] hdr_byte
);

  localparam logic [31:0] c_image_size = 32'(WIDTH * HEIGHT * 3);
  localparam logic [31:0] c_file_size  = 32'(BMP_HDR_BYTES) + c_image_size;

  // Fields never overlap, so OR-ing them yields the byte; reserved and
  // compression fields are zero and need no term.
  assign hdr_byte = le_field(32'h0000_4D42,       index, OFF_SIGNATURE,   3'd2)
                  | le_field(c_file_size,         index, OFF_FILE_SIZE,   3'd4)
                  | le_field(32'(BMP_HDR_BYTES),  index, OFF_DATA_OFFSET, 3'd4)
                  | le_field(32'd40,              index, OFF_DIB_SIZE,    3'd4)
                  | le_field(32'(WIDTH),          index, OFF_WIDTH,       3'd4)
                  | le_field(32'(HEIGHT),         index, OFF_HEIGHT,      3'd4)
                  | le_field(32'd1,               index, OFF_PLANES,      3'd2)
                  | le_field(32'd24,              index, OFF_BPP,         3'd2)
                  | le_field(c_image_size,        index, OFF_IMAGE_SIZE,  3'd4);

endmodule

`default_nettype wire

// File: rtl/img_write.sv
// ============================================================================
// Module   : img_write
// Brief    : Streams a 24-bit BMP file (header + bottom-up pixel rows) as byte writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module img_write
  import img_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH_DEF,
  parameter int HEIGHT = IMG_HEIGHT_DEF,
  parameter int ADDR_W = 21
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              hsync_in,
  output logic              in_ready,
  input  logic [7:0]        r0,
  input  logic [7:0]        g0,
  input  logic [7:0]        b0,
  input  logic [7:0]        r1,
  input  logic [7:0]        g1,
  input  logic [7:0]        b1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              write_done
);

  localparam logic [ADDR_W-1:0] c_hdr_bytes = ADDR_W'(BMP_HDR_BYTES);
  localparam logic [ADDR_W-1:0] c_width     = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] c_last_col  = ADDR_W'(WIDTH - 2);
  localparam logic [ADDR_W-1:0] c_last_row  = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] c_px_bytes  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] c_col_step  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] c_one       = ADDR_W'(1);
  localparam logic [5:0]        c_hdr_end   = 6'(BMP_HDR_BYTES);

  img_state_t        r_state;
  logic [5:0]        r_hdr_idx;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;
  logic [2:0]        r_byte_k;
  logic [47:0]       r_pix;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;

  logic [7:0]        w_hdr_byte;
  logic [ADDR_W-1:0] w_pair_base;
  logic              w_last_pair;

  bmp_header_rom #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_hdr_rom (
    .index    (r_hdr_idx),
    .hdr_byte (w_hdr_byte)
  );

  // BMP stores rows bottom-up, so input row 0 maps to the last file row.
  assign w_pair_base = c_hdr_bytes + ((c_last_row - r_row) * c_width + r_col) * c_px_bytes;
  assign w_last_pair = (r_row == c_last_row) && (r_col == c_last_col);

  assign in_ready   = (r_state == S_ACCEPT);
  assign write_done = (r_state == S_DONE);
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

  // Write outputs are registered one step ahead of the byte they carry, so
  // HEADER runs one extra cycle (index 54) to retire its last write before ACCEPT.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= S_HEADER;
      r_hdr_idx   <= 6'd0;
      r_row       <= '0;
      r_col       <= '0;
      r_byte_k    <= 3'd0;
      r_pix       <= 48'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
    end else begin
      case (r_state)
        S_HEADER: begin
          if (r_hdr_idx == c_hdr_end) begin
            r_mem_we  <= 1'b0;
            r_hdr_idx <= 6'd0;
            r_state   <= S_ACCEPT;
          end else begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= ADDR_W'(r_hdr_idx);
            r_mem_wdata <= w_hdr_byte;
            r_hdr_idx   <= r_hdr_idx + 6'd1;
          end
        end
        S_ACCEPT: begin
          if (hsync_in) begin
            r_pix       <= {r1, g1, b1, r0, g0, b0};
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_pair_base;
            r_mem_wdata <= b0;
            r_byte_k    <= 3'd0;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_byte_k == 3'd5) begin
            r_mem_we <= 1'b0;
            if (r_col == c_last_col) begin
              r_col <= '0;
              r_row <= r_row + c_one;
            end else begin
              r_col <= r_col + c_col_step;
            end
            r_state <= w_last_pair ? S_DONE : S_ACCEPT;
          end else begin
            r_byte_k    <= r_byte_k + 3'd1;
            r_mem_addr  <= r_mem_addr + c_one;
            r_mem_wdata <= r_pix[15:8];
            r_pix       <= {8'h00, r_pix[47:8]};
          end
        end
        S_DONE: begin
          r_mem_we <= 1'b0;
        end
        default: begin
          r_mem_we <= 1'b0;
          r_state  <= S_HEADER;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_img_write.sv
// ============================================================================
// Module   : tb_img_write
// Brief    : Self-checking bench for img_write at WIDTH=4, HEIGHT=2, ADDR_W=7.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_img_write;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int AW    = 7;
  localparam int NPAIR = 4;
  localparam int HDR   = 54;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b0;
  logic          hsync_in = 1'b0;
  logic [7:0]    r0 = 8'h00, g0 = 8'h00, b0 = 8'h00;
  logic [7:0]    r1 = 8'h00, g1 = 8'h00, b1 = 8'h00;
  logic          in_ready, mem_we, write_done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [7:0] r0, g0, b0, r1, g1, b1; int base; } pair_vec_t;
  typedef struct { int addr; logic [7:0] val; } spot_t;

  pair_vec_t  pairs [NPAIR];
  spot_t      spots [8];
  logic [7:0] hdr [HDR];
  logic [7:0] shadow [0:(1<<AW)-1];
  wr_t        exp_q [$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_writes = 0;

  img_write #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .hsync_in(hsync_in), .in_ready(in_ready),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .write_done(write_done)
  );

  always #5 HCLK = ~HCLK;

  // Every write the DUT issues is matched in order against the expected queue.
  always @(negedge HCLK) begin : monitor
    wr_t e;
    if (mem_we === 1'b1) begin
      n_writes++;
      shadow[mem_addr] = mem_wdata;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got addr=%0d data=0x%02h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          n_fail++;
          $display("FAIL write_order: got addr=%0d data=0x%02h, required addr=%0d data=0x%02h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic put32(input int off, input int v);
    for (int b = 0; b < 4; b++) hdr[off+b] = 8'(v >> (8*b));
  endtask

  task automatic push_header();
    for (int a = 0; a < HDR; a++) exp_q.push_back('{addr: AW'(a), data: hdr[a]});
  endtask

  task automatic push_pair(input int i);
    int b;
    b = pairs[i].base;
    exp_q.push_back('{addr: AW'(b),   data: pairs[i].b0});
    exp_q.push_back('{addr: AW'(b+1), data: pairs[i].g0});
    exp_q.push_back('{addr: AW'(b+2), data: pairs[i].r0});
    exp_q.push_back('{addr: AW'(b+3), data: pairs[i].b1});
    exp_q.push_back('{addr: AW'(b+4), data: pairs[i].g1});
    exp_q.push_back('{addr: AW'(b+5), data: pairs[i].r1});
  endtask

  task automatic drive_pair(input int i);
    r0 = pairs[i].r0; g0 = pairs[i].g0; b0 = pairs[i].b0;
    r1 = pairs[i].r1; g1 = pairs[i].g1; b1 = pairs[i].b1;
    hsync_in = 1'b1;
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < budget) begin
      @(negedge HCLK);
      k++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic random_inputs();
    hsync_in = 1'($urandom_range(0, 1));
    r0 = 8'($urandom); g0 = 8'($urandom); b0 = 8'($urandom);
    r1 = 8'($urandom); g1 = 8'($urandom); b1 = 8'($urandom);
  endtask

  // One pair, with junk on hsync_in/pixels for the whole DRAIN; ends on the next ACCEPT cycle.
  task automatic send_pair_jitter(input int i);
    wait_ready(20);
    drive_pair(i);
    push_pair(i);
    for (int k = 0; k < 6; k++) begin
      @(negedge HCLK);
      random_inputs();
    end
    @(negedge HCLK);
    hsync_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_in_ready"},   32'(in_ready),   32'd0);
    check({tag, "_write_done"}, 32'(write_done), 32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
  endtask

  initial begin : main
    int base, last, pi, ready_cnt;

    pairs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 66};
    pairs[1] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 72};
    pairs[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 54};
    pairs[3] = '{8'h7A, 8'h8B, 8'h9C, 8'hAD, 8'hBE, 8'hCF, 60};
    spots[0] = '{0, 8'h42};  spots[1] = '{1, 8'h4D};  spots[2] = '{2, 8'h4E};
    spots[3] = '{10, 8'h36}; spots[4] = '{18, 8'h04}; spots[5] = '{22, 8'h02};
    spots[6] = '{28, 8'h18}; spots[7] = '{34, 8'h18};

    for (int a = 0; a < HDR; a++) hdr[a] = 8'h00;
    hdr[0] = 8'h42; hdr[1] = 8'h4D;
    put32(2, 78); put32(10, 54); put32(14, 40); put32(18, W); put32(22, H);
    hdr[26] = 8'd1; hdr[28] = 8'd24;
    put32(34, 24);

    // Reset state
    #1 HRESET = 1'b1;
    repeat (2) @(negedge HCLK);
    check_reset_outputs("reset");

    // Header write-out
    push_header();
    HRESET = 1'b0;
    wait_ready(80);
    check("header_count", 32'(n_writes), 32'd54);
    check("header_queue_left", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("hdr_byte%0d", spots[i].addr), 32'(shadow[spots[i].addr]), 32'(spots[i].val));

    // Full frame with hsync_in held high: one acceptance per 7 cycles
    hsync_in = 1'b1;
    last = -1; pi = 0; ready_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge HCLK);
      if (in_ready === 1'b1) begin
        ready_cnt++;
        if (last >= 0) check("ready_interval", 32'(c - last), 32'd7);
        last = c;
        if (pi < NPAIR) begin
          drive_pair(pi);
          push_pair(pi);
          pi++;
        end
      end
    end
    check("ready_pulses", 32'(ready_cnt), 32'd4);
    check("pixel_writes", 32'(n_writes - HDR), 32'd24);
    check("frame_queue_left", 32'(exp_q.size()), 32'd0);
    check("done_high", 32'(write_done), 32'd1);

    // hsync_in activity in DONE is ignored and write_done is sticky
    base = n_writes;
    for (int c = 0; c < 20; c++) begin
      @(negedge HCLK);
      random_inputs();
    end
    check("done_no_writes", 32'(n_writes - base), 32'd0);
    check("done_sticky", 32'(write_done), 32'd1);
    check("done_not_ready", 32'(in_ready), 32'd0);

    // New frame: reset clears DONE asynchronously
    hsync_in = 1'b0;
    #2 HRESET = 1'b1;
    #1 check("reset_clears_done", 32'(write_done), 32'd0);
    @(negedge HCLK);
    exp_q.delete();
    push_header();
    HRESET = 1'b0;
    base = n_writes;
    wait_ready(80);
    check("header2_count", 32'(n_writes - base), 32'd54);

    // Two pairs with junk toggling on the inputs during DRAIN
    base = n_writes;
    send_pair_jitter(0);
    send_pair_jitter(1);
    check("jitter_pair_writes", 32'(n_writes - base), 32'd12);
    check("jitter_queue_left", 32'(exp_q.size()), 32'd0);

    // Abort mid-DRAIN of the third pair
    wait_ready(20);
    drive_pair(2);
    push_pair(2);
    @(negedge HCLK);
    hsync_in = 1'b0;
    @(negedge HCLK);
    check("drain_we_before_abort", 32'(mem_we), 32'd1);
    #2 HRESET = 1'b1;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    @(negedge HCLK);
    push_header();
    HRESET = 1'b0;
    base = n_writes;
    wait_ready(80);
    check("header3_count", 32'(n_writes - base), 32'd54);
    send_pair_jitter(0);
    repeat (3) @(negedge HCLK);
    check("restart_queue_left", 32'(exp_q.size()), 32'd0);
    check("restart_row0_b0", 32'(shadow[66]), 32'h33);
    check("restart_row0_r1", 32'(shadow[71]), 32'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/img_write.md
IMG_WRITE -- requirements
Module: img_write

Interface
REQ-001 Parameter WIDTH, default 768, image width in pixels; SHALL be even and WIDTH*3 a multiple of 4.
REQ-002 Parameter HEIGHT, default 512, image height in rows.
REQ-003 Parameter ADDR_W, default 21, byte-address width; SHALL hold 54 + WIDTH*HEIGHT*3.
REQ-004 Timing is fixed: one clock; reset is asynchronous and active-high.
REQ-005 Clock and reset ports:
- HCLK, input, 1 bit: sole clock, rising edge.
- HRESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 Pixel input ports:
- hsync_in, input, 1 bit: pixel-pair valid.
- in_ready, output, 1 bit: block can accept a pair.
- r0/g0/b0, input, 8 bits each: even pixel.
- r1/g1/b1, input, 8 bits each: odd pixel.
REQ-007 Memory and status ports:
- mem_we, output, 1 bit: byte write strobe.
- mem_addr, output, ADDR_W bits: BMP file byte address.
- mem_wdata, output, 8 bits: byte value.
- write_done, output, 1 bit: whole file written.

Function
REQ-008 The FSM SHALL use states HEADER, ACCEPT, DRAIN and DONE; HEADER is entered on reset release.
REQ-009 HEADER SHALL write 54 bytes, one per cycle, to addresses 0..53, mem_we=1, then go to ACCEPT.
REQ-010 Header fields are little-endian:
- "BM"; file size 54+W*H*3; reserved 0; data offset 54.
- DIB size 40; WIDTH; HEIGHT; planes 1; bpp 24; compression 0.
- Image size W*H*3; all remaining bytes 0.
REQ-011 in_ready SHALL be 1 only in ACCEPT; a beat is accepted when hsync_in=1 and in_ready=1.
REQ-012 On acceptance, the six input bytes SHALL be registered and the FSM SHALL enter DRAIN the next cycle.
REQ-013 DRAIN SHALL write six bytes on consecutive cycles in the order B0,G0,R0,B1,G1,R1; throughput is one pair per 7 cycles.
REQ-014 Input arrives row-major, top row first; byte address = 54 + ((HEIGHT-1-row)*WIDTH + col)*3 + k, with k=0/1/2 for B/G/R (BMP bottom-up).
REQ-015 Column and row counters SHALL advance by 2 pixels per pair; col wraps from WIDTH-2 to 0 with row+1.
REQ-016 After the DRAIN of pair (HEIGHT-1, WIDTH-2), the FSM SHALL enter DONE; otherwise it returns to ACCEPT.
REQ-017 In DONE, write_done SHALL be 1, mem_we=0 and in_ready=0; write_done is sticky until reset.
REQ-018 hsync_in and pixel inputs SHALL be ignored in HEADER, DRAIN and DONE; no pair is lost or double-counted.
REQ-019 mem_we SHALL be 0 in ACCEPT; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-020 All address arithmetic SHALL be ADDR_W wide with no overflow for legal parameters.

Reset
REQ-021 HRESET=1 SHALL asynchronously force:
- state=HEADER, header index=0, row=0, col=0;
- mem_we=0, in_ready=0, write_done=0, mem_addr=0, mem_wdata=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame; after release, the header is rewritten and the frame restarts at row 0.

Structure
REQ-023 Package img_pkg SHALL hold:
- the FSM state enum;
- BMP_HDR_BYTES=54;
- header field offsets;
- default WIDTH/HEIGHT.
REQ-024 Header bytes SHALL come from sub-module bmp_header_rom: index[5:0] and WIDTH/HEIGHT parameters in, byte out, combinational.

Verification (WIDTH=4, HEIGHT=2, ADDR_W=7)
REQ-025 Release reset -> 54 writes at addr 0..53:
- byte0=0x42, byte1=0x4D, byte2=0x4E (file size 78);
- byte10=0x36, byte18=0x04, byte22=0x02, byte28=0x18, byte34=0x18;
- then in_ready=1.
REQ-026 First pair R0G0B0=11,22,33 and R1G1B1=44,55,66 -> writes 33@66, 22@67, 11@68, 66@69, 55@70, 44@71 on the six cycles after acceptance.
REQ-027 Four pairs with hsync_in held high -> in_ready pulses once per 7 cycles, exactly 24 pixel writes, the last pair lands at addr 60..65, then write_done=1 stays high.
REQ-028 hsync_in toggled during DRAIN and DONE -> no extra writes, and the pair count is unchanged.
REQ-029 HRESET pulsed after 2 pairs -> outputs zero immediately, the header is rewritten from addr 0, and the next pair lands at addr 66.
